// File: rtl/conv_window_scheduler_pkg.sv
// Shared definitions for the convolution window scheduler: FSM state encoding
// and the width used for window-position arithmetic.
package conv_window_scheduler_pkg;

    localparam int unsigned POS_W = 5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_ROW = 3'd1,
        S_MAC      = 3'd2,
        S_WIN_END  = 3'd3,
        S_ROW_END  = 3'd4,
        S_FIN      = 3'd5
    } state_t;

endpackage

// File: rtl/conv_window_counter.sv
// Element index k and window position p, with the stride advance and the
// last-element / further-window compares used by the scheduler FSM.
module conv_window_counter
    import conv_window_scheduler_pkg::*;
#(
    parameter int STRIDE_SIZE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   k_inc,
    input  logic                   k_clr,
    input  logic                   p_adv,
    input  logic [2:0]             filter_size,
    input  logic [2:0]             if_size,
    input  logic [STRIDE_SIZE-1:0] stride,
    output logic [2:0]             k,
    output logic [POS_W-1:0]       p,
    output logic                   last_elem,
    output logic                   more_win
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            k <= '0;
            p <= '0;
        end else if (clr) begin
            k <= '0;
            p <= '0;
        end else begin
            if (k_clr) begin
                k <= '0;
            end else if (k_inc) begin
                k <= k + 3'd1;
            end
            if (p_adv) begin
                p <= p + POS_W'(stride);
            end
        end
    end

    // Only consulted in MAC, where filter_size is known to be nonzero.
    always_comb begin
        last_elem = (k == filter_size - 3'd1);
        more_win  = (p + POS_W'(stride) + POS_W'(filter_size)) <= POS_W'(if_size);
    end

endmodule

// File: rtl/conv_window_scheduler.sv
// Sequencer for one convolution layer pass: walks the filter window across each
// IF row by stride, issuing scratchpad addresses and partial-sum/row/pass pulses.
module conv_window_scheduler
    import conv_window_scheduler_pkg::*;
#(
    parameter int IF_ADDRESS_SIZE     = 8,
    parameter int FILTER_ADDRESS_SIZE = 8,
    parameter int STRIDE_SIZE         = 2,
    parameter int ROW_CNT_SIZE        = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [2:0]                     filter_size,
    input  logic [2:0]                     if_size,
    input  logic [STRIDE_SIZE-1:0]         stride,
    input  logic [ROW_CNT_SIZE-1:0]        row_count,
    input  logic                           row_ready,
    input  logic                           stall_output_buffer,
    output logic                           row_ack,
    output logic                           can_mult,
    output logic [FILTER_ADDRESS_SIZE-1:0] filter_raddr,
    output logic [IF_ADDRESS_SIZE-1:0]     if_raddr,
    output logic                           par_done,
    output logic                           row_done,
    output logic                           done,
    output logic                           busy
);

    state_t state_q, state_d;

    logic [2:0]              fs_q, ifs_q;
    logic [STRIDE_SIZE-1:0]  stride_q;
    logic [ROW_CNT_SIZE-1:0] row_count_q, row_cnt_q;

    logic load_cfg, row_clr, row_inc;
    logic ctr_clr, k_inc, k_clr, p_adv;
    logic [2:0]       k;
    logic [POS_W-1:0] p;
    logic last_elem, more_win, window_ok;

    logic row_ack_d, can_mult_d, par_done_d, row_done_d, done_d;
    logic [FILTER_ADDRESS_SIZE-1:0] filter_raddr_d;
    logic [IF_ADDRESS_SIZE-1:0]     if_raddr_d;

    conv_window_counter #(
        .STRIDE_SIZE (STRIDE_SIZE)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .clr         (ctr_clr),
        .k_inc       (k_inc),
        .k_clr       (k_clr),
        .p_adv       (p_adv),
        .filter_size (fs_q),
        .if_size     (ifs_q),
        .stride      (stride_q),
        .k           (k),
        .p           (p),
        .last_elem   (last_elem),
        .more_win    (more_win)
    );

    assign window_ok = (fs_q != 3'd0) && (fs_q <= ifs_q);
    assign busy      = (state_q != S_IDLE);

    // Pulse outputs are computed with the transition and registered at the same
    // edge, so each pulse is visible in the cycle after its action is taken.
    always_comb begin
        state_d        = state_q;
        load_cfg       = 1'b0;
        row_clr        = 1'b0;
        row_inc        = 1'b0;
        ctr_clr        = 1'b0;
        k_inc          = 1'b0;
        k_clr          = 1'b0;
        p_adv          = 1'b0;
        row_ack_d      = 1'b0;
        can_mult_d     = 1'b0;
        par_done_d     = 1'b0;
        row_done_d     = 1'b0;
        done_d         = 1'b0;
        filter_raddr_d = filter_raddr;
        if_raddr_d     = if_raddr;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_cfg = 1'b1;
                    row_clr  = 1'b1;
                    state_d  = S_WAIT_ROW;
                end
            end
            S_WAIT_ROW: begin
                if (row_ready) begin
                    row_ack_d = 1'b1;
                    ctr_clr   = 1'b1;
                    state_d   = window_ok ? S_MAC : S_ROW_END;
                end
            end
            S_MAC: begin
                if (!stall_output_buffer) begin
                    can_mult_d     = 1'b1;
                    filter_raddr_d = FILTER_ADDRESS_SIZE'(k);
                    if_raddr_d     = IF_ADDRESS_SIZE'(p + POS_W'(k));
                    if (last_elem) begin
                        state_d = S_WIN_END;
                    end else begin
                        k_inc = 1'b1;
                    end
                end
            end
            S_WIN_END: begin
                if (!stall_output_buffer) begin
                    par_done_d = 1'b1;
                    k_clr      = 1'b1;
                    if (more_win) begin
                        p_adv   = 1'b1;
                        state_d = S_MAC;
                    end else begin
                        state_d = S_ROW_END;
                    end
                end
            end
            S_ROW_END: begin
                row_done_d = 1'b1;
                row_inc    = 1'b1;
                state_d    = (row_cnt_q + ROW_CNT_SIZE'(1) == row_count_q) ? S_FIN : S_WAIT_ROW;
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            fs_q         <= '0;
            ifs_q        <= '0;
            stride_q     <= '0;
            row_count_q  <= '0;
            row_cnt_q    <= '0;
            row_ack      <= 1'b0;
            can_mult     <= 1'b0;
            par_done     <= 1'b0;
            row_done     <= 1'b0;
            done         <= 1'b0;
            filter_raddr <= '0;
            if_raddr     <= '0;
        end else begin
            state_q      <= state_d;
            row_ack      <= row_ack_d;
            can_mult     <= can_mult_d;
            par_done     <= par_done_d;
            row_done     <= row_done_d;
            done         <= done_d;
            filter_raddr <= filter_raddr_d;
            if_raddr     <= if_raddr_d;
            if (load_cfg) begin
                fs_q        <= filter_size;
                ifs_q       <= if_size;
                stride_q    <= (stride == '0) ? STRIDE_SIZE'(1) : stride;
                row_count_q <= (row_count == '0) ? ROW_CNT_SIZE'(1) : row_count;
            end
            if (row_clr) begin
                row_cnt_q <= '0;
            end else if (row_inc) begin
                row_cnt_q <= row_cnt_q + ROW_CNT_SIZE'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench for conv_window_scheduler: directed and randomized passes
// compared against an arithmetic model of the window schedule.
module tb_conv_window_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] filter_size = '0;
    logic [2:0] if_size = '0;
    logic [1:0] stride = '0;
    logic [3:0] row_count = '0;
    logic       row_ready = 1'b0;
    logic       stall_output_buffer = 1'b0;
    logic       row_ack, can_mult, par_done, row_done, done, busy;
    logic [7:0] filter_raddr, if_raddr;

    int tests = 0;
    int fails = 0;

    conv_window_scheduler #(
        .IF_ADDRESS_SIZE     (8),
        .FILTER_ADDRESS_SIZE (8),
        .STRIDE_SIZE         (2),
        .ROW_CNT_SIZE        (4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .filter_size         (filter_size),
        .if_size             (if_size),
        .stride              (stride),
        .row_count           (row_count),
        .row_ready           (row_ready),
        .stall_output_buffer (stall_output_buffer),
        .row_ack             (row_ack),
        .can_mult            (can_mult),
        .filter_raddr        (filter_raddr),
        .if_raddr            (if_raddr),
        .par_done            (par_done),
        .row_done            (row_done),
        .done                (done),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_can_mult"}, int'(can_mult), 0);
        check({tag, "_par_done"}, int'(par_done), 0);
        check({tag, "_row_ack"}, int'(row_ack), 0);
        check({tag, "_row_done"}, int'(row_done), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_filter_raddr"}, int'(filter_raddr), 0);
        check({tag, "_if_raddr"}, int'(if_raddr), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    // Runs one full pass and compares against the schedule derived from the
    // configuration: window count, address list and completion cycle.
    task automatic run_pass(input int fs, input int ifs, input int st, input int rc,
                            input bit late_row, input bit stall_dir,
                            input bit rand_stall, input bit meddle);
        int s, r, w, exp_done, extra, cyc, npar, nack, nrow;
        int late_cnt, stall_left, sp, stall_cnt, last_f, last_i, n;
        bit got_done, stall_prev, ready_prev;
        int exp_q[$];
        int got_q[$];

        s = (st == 0) ? 1 : st;
        r = (rc == 0) ? 1 : rc;
        w = (fs >= 1 && fs <= ifs) ? (ifs - fs) / s + 1 : 0;
        for (int row = 0; row < r; row++)
            for (int win = 0; win < w; win++)
                for (int kk = 0; kk < fs; kk++)
                    exp_q.push_back((kk << 8) | (win * s + kk));
        exp_done = r * (2 + w * (fs + 1)) + 1;
        extra    = (late_row && r >= 2) ? 5 : 0;

        filter_size = 3'(fs);
        if_size     = 3'(ifs);
        stride      = 2'(st);
        row_count   = 4'(rc);
        row_ready   = 1'b1;
        stall_output_buffer = 1'b0;
        start = 1'b1;
        step();
        start  = 1'b0;
        last_f = int'(filter_raddr);
        last_i = int'(if_raddr);
        check("busy_after_start", int'(busy), 1);

        cyc = 0; npar = 0; nack = 0; nrow = 0; late_cnt = 0;
        stall_left = 0; sp = 0; stall_cnt = 0; got_done = 1'b0;
        while (!got_done && cyc < 1000) begin
            stall_prev = stall_output_buffer;
            ready_prev = row_ready;
            step();
            cyc++;
            if (stall_prev) begin
                check("stall_can_mult", int'(can_mult), 0);
                check("stall_par_done", int'(par_done), 0);
            end
            if (!ready_prev) check("row_ack_without_ready", int'(row_ack), 0);
            if (can_mult) begin
                got_q.push_back((int'(filter_raddr) << 8) | int'(if_raddr));
                last_f = int'(filter_raddr);
                last_i = int'(if_raddr);
            end else begin
                check("hold_filter_raddr", int'(filter_raddr), last_f);
                check("hold_if_raddr", int'(if_raddr), last_i);
            end
            npar += int'(par_done);
            nack += int'(row_ack);
            if (late_cnt > 0) begin
                late_cnt--;
                if (late_cnt == 0) row_ready = 1'b1;
            end
            if (row_done) begin
                nrow++;
                if (late_row && nrow == 1) begin
                    row_ready = 1'b0;
                    late_cnt  = 5;
                end
            end
            if (done) begin
                got_done = 1'b1;
                check("busy_after_done", int'(busy), 0);
            end else begin
                check("busy_during_pass", int'(busy), 1);
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) stall_output_buffer = 1'b0;
            end
            if (stall_dir) begin
                if (sp == 0 && can_mult && got_q.size() == 1) begin
                    stall_output_buffer = 1'b1; stall_left = 3; sp = 1;
                end else if (sp == 1 && stall_left == 0 && can_mult && int'(filter_raddr) == fs - 1) begin
                    stall_output_buffer = 1'b1; stall_left = 2; sp = 2;
                end
            end
            if (rand_stall) stall_output_buffer = !got_done && ($urandom_range(0, 3) == 0);
            if (stall_output_buffer) stall_cnt++;
            if (meddle && cyc == 4) begin
                start       = 1'b1;
                filter_size = 3'($urandom);
                if_size     = 3'($urandom);
                stride      = 2'($urandom);
                row_count   = 4'($urandom);
            end
            if (meddle && cyc == 5) start = 1'b0;
        end
        start = 1'b0;
        stall_output_buffer = 1'b0;
        row_ready = 1'b1;

        check("done_seen", int'(got_done), 1);
        if (rand_stall)
            check("done_cycle_in_range",
                  int'(cyc >= exp_done + extra && cyc <= exp_done + extra + stall_cnt), 1);
        else
            check("done_cycle", cyc, exp_done + extra + stall_cnt);
        check("can_mult_count", got_q.size(), exp_q.size());
        check("par_done_count", npar, r * w);
        check("row_done_count", nrow, r);
        check("row_ack_count", nack, r);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check("addr_seq", got_q[i], exp_q[i]);
    endtask

    task automatic reset_mid_mac();
        bit found;
        filter_size = 3'd3; if_size = 3'd7; stride = 2'd2; row_count = 4'd1;
        row_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (can_mult && filter_raddr == 8'd0) found = 1'b1;
        end
        check("reach_mac_k1", int'(found), 1);
        rst = 1'b0;
        step();
        check_all_zero("mid_reset");
        rst = 1'b1;
        step();
        check("idle_after_reset", int'(busy), 0);
    endtask

    initial begin
        rst = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b1;
        step();
        check("idle_no_start", int'(busy), 0);

        run_pass(3, 7, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_pass(4, 4, 0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_pass(5, 3, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_pass(3, 7, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        reset_mid_mac();
        run_pass(3, 7, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_pass(2, 6, 1, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        run_pass(0, 5, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            run_pass(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
